pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic, parametrised inter-stage pipeline register for the RISC-V core. It replaces the fixed per-stage register blocks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a packed payload and adds a valid/ready handshake, stall back-pressure, flush, and bubble-safe control clearing. An optional skid slot gives full throughput with a registered `in_ready`.

## Interface
Parameters:
- `WIDTH`, default 32: total payload width in bits. Must be ≥ 1.
- `CTRL_WIDTH`, default 3: number of low payload bits that are control fields (e.g. RegWrite, ResultSrc). These bits are forced to 0 whenever the output is a bubble. Must satisfy 0 ≤ `CTRL_WIDTH` ≤ `WIDTH`.
- `SKID`, default 0:
  - 0 = single-entry register; `in_ready` is combinational from `out_ready`.
  - 1 = two-entry skid buffer; `in_ready` is registered.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills all held entries and any input offered this cycle.
- `in_valid`  in  1  upstream stage presents a payload.
- `in_ready`  out  1  this block accepts the payload this cycle.
- `in_data`  in  `WIDTH`  upstream payload.
- `out_valid`  out  1  `out_data` holds a live instruction.
- `out_ready`  in  1  downstream stage consumes the payload (deassert = stall).
- `out_data`  out  `WIDTH`  registered payload; bits [`CTRL_WIDTH`-1:0] are 0 when `out_valid`=0.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid & in_ready` at a rising edge.
  - Output transfer occurs when `out_valid & out_ready` at a rising edge.
- Priority per edge: `rst` > `flush` > normal transfer.
- Reset values: `out_valid`=0, `out_data`=0, skid entry empty. `in_ready`=0 while `rst`=1; it is 1 on the first cycle after reset.
- Flush: clears `out_valid` and the skid entry. An input offered in the flush cycle is dropped even if `in_ready`=1. The data bits above `CTRL_WIDTH` may retain stale values; control bits read 0.
- SKID=0:
  - `in_ready = out_ready | ~out_valid` (and 0 during `rst`).
  - On an input transfer, `out_data` loads `in_data` and `out_valid` becomes 1.
  - On an output transfer without an input transfer, `out_valid` becomes 0.
  - Otherwise the register holds.
- SKID=1: state enum `{EMPTY, MAIN, FULL}`.
  - `in_ready = (state != FULL)`.
  - EMPTY: on input transfer, load main → MAIN.
  - MAIN:
    - input and output transfer together: load main → MAIN;
    - input only: load skid → FULL;
    - output only → EMPTY.
  - FULL:
    - on output transfer, main ← skid → MAIN;
    - no input is accepted in FULL.
  - `out_valid = (state != EMPTY)`.
- Order is strictly preserved; no payload is duplicated or lost except by `flush` or `rst`.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`, in both modes.
- Throughput: 1 payload per cycle while `out_ready`=1, in both modes.
- SKID=0: combinational path from `out_ready` to `in_ready`.
- SKID=1: no combinational path from `out_ready` to `in_ready` or from input to output. `in_ready` depends on state only.
- `out_data` and `out_valid` come directly from flops in both modes.
- Reset mid-stall: all held entries are discarded in the same edge.
- Simultaneous `flush` and `out_ready`: the downstream output transfer that edge still counts as consumed. The stage is empty afterwards.

## Structure
- Shared package `pipe_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY, MAIN, FULL} pipe_state_t`;
  - per-stage payload struct typedefs (`mem_wb_t`, `ex_mem_t`, …), packed with control fields in the LSBs so that `CTRL_WIDTH` = width of the control sub-struct;
  - `localparam` widths for each of those structs.
- Mode selection uses a `generate` on `SKID`.
- No sub-module: both modes are small enough to sit inline. The skid slot is a plain register plus valid.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 and `in_data`=32'hDEAD_BEEF → `out_valid`=0, `out_data`=0, `in_ready`=0. After release, `in_ready`=1.
- Stream: `out_ready`=1, 8 back-to-back inputs 1..8 → outputs 1..8 appear one cycle later, one per cycle, with no gaps. Run in both modes.
- Stall, SKID=1: feed 1, 2, 3 with `out_ready`=0 → state FULL after 2, `in_ready`=0, 3 is held upstream. Raise `out_ready` → outputs 1, 2, 3 in order, none lost.
- Stall, SKID=0: `out_ready`=0 with `out_valid`=1 → `in_ready`=0 the same cycle and `out_data` is stable for the whole stall.
- Flush: with FULL (entries 5, 6) and `in_valid`=1 data 7, pulse `flush` → next cycle `out_valid`=0, `out_data`[`CTRL_WIDTH`-1:0]=0, and 7 never appears at the output.
- Flush + reset overlap: assert `rst` and `flush` together mid-stream → reset values result. The first post-reset input (data 9) emerges after 1 cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the core's inter-stage registers: skid FSM states and per-stage payloads.
// Control sub-structs sit in the LSBs so CTRL_WIDTH is simply the width of that sub-struct.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Writeback controls.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  // Memory-stage controls nest the writeback controls beneath them.
  typedef struct packed {
    logic     mem_write;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  // Execute-stage controls.
  typedef struct packed {
    logic       jump;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  // IF/ID carries no control fields; a bubble here is marked by valid alone.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    ex_ctrl_t    ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    mem_ctrl_t   ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    wb_ctrl_t    ctrl;
  } mem_wb_t;

  localparam int unsigned IfIdWidth      = $bits(if_id_t);
  localparam int unsigned IfIdCtrlWidth  = 0;
  localparam int unsigned IdExWidth      = $bits(id_ex_t);
  localparam int unsigned IdExCtrlWidth  = $bits(ex_ctrl_t);
  localparam int unsigned ExMemWidth     = $bits(ex_mem_t);
  localparam int unsigned ExMemCtrlWidth = $bits(mem_ctrl_t);
  localparam int unsigned MemWbWidth     = $bits(mem_wb_t);
  localparam int unsigned MemWbCtrlWidth = $bits(wb_ctrl_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and bubble control
// clearing. SKID=1 adds a second entry so in_ready can be driven from state alone.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CTRL_WIDTH = 3,
  parameter int unsigned SKID       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Ones over the control field; all-zero when CTRL_WIDTH is 0.
  localparam logic [WIDTH-1:0] CtrlMask = {WIDTH{1'b1}} >> (WIDTH - CTRL_WIDTH);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  if (SKID == 0) begin : g_single
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready  = ~rst & (out_ready | ~valid_q);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Control bits are cleared in the flop itself whenever the entry turns into a bubble,
    // keeping out_data a pure register output.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        data_d  = data_q & ~CtrlMask;
      end else if (in_xfer) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (out_xfer) begin
        valid_d = 1'b0;
        data_d  = data_q & ~CtrlMask;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

  end else begin : g_skid
    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    assign in_ready  = ~rst & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q & ~CtrlMask;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_d  = in_data;
              state_d = MAIN;
            end
          end
          MAIN: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              skid_d  = in_data;
              state_d = FULL;
            end else if (out_xfer) begin
              main_d  = main_q & ~CtrlMask;
              state_d = EMPTY;
            end
          end
          FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = MAIN;
            end
          end
          default: begin
            state_d = EMPTY;
            main_d  = main_q & ~CtrlMask;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end

endmodule
